booth_skip_controller: RTL and testbench
========================================

// Module: booth_skip_controller
// PURPOSE
//   Control FSM for the shift-add multiplier datapath. It drives that datapath's
//   op, A_shft_amt, B_shft_amt and done inputs, and observes its B output.
//   It applies radix-2 Booth recoding to signed B with run skipping. Each active
//   cycle consumes all bits up to and including the next bit transition, so
//   ACC = A*B is produced in one add/sub per Booth transition.
// PARAMETERS
//   WIDTH  4  multiplier (B) width in bits; legal range 2..7 so that shift amounts fit 3 bits
// PORTS
//   clk          in   1      clock
//   rstN         in   1      async active-low reset; the datapath loads operands on the same reset
//   start        in   1      begin multiplication; sampled only in IDLE
//   B            in   WIDTH  datapath B register (logically right-shifted each active cycle)
//   op           out  1      1 = ACC += A<<A_shft_amt, 0 = ACC -= A<<A_shft_amt
//   A_shft_amt   out  3      absolute bit position of the current Booth term
//   B_shft_amt   out  3      bits of B consumed this cycle
//   done         out  1      1 = datapath holds; 0 = datapath updates this edge
//   busy         out  1      1 in RUN
//   ready        out  1      1 in DONE (result valid in ACC)
//   step_cnt     out  3      number of add/sub cycles issued so far
// BEHAVIOUR
//   Reset: state=IDLE, pos=0, prev=0, step_cnt=0. Outputs are op=1, shifts=0,
//     done=1, busy=0, ready=0.
//   State registers: state{IDLE,RUN,DONE}, pos (3b, original index of B[0]), prev (1b).
//   IDLE: done=1. When start=1: RUN next cycle, with pos=0, prev=0, step_cnt=0.
//   RUN (Mealy; outputs combinational from state and B):
//     - valid bits: n = WIDTH-pos. Bit i of B is in scope for i<n.
//     - k = smallest i<n with B[i] != (i==0 ? prev : B[i-1]).
//     - If k is found: done=0, op=~B[k] (0->1 transition subtracts, 1->0 adds),
//       A_shft_amt=pos+k, B_shft_amt=k+1. Next cycle: pos+=k+1, prev=B[k], step_cnt+=1.
//     - If no k is found (including n==0): done=1, shifts=0, op=1. Next state is DONE.
//       No datapath update occurs this cycle.
//     - An open run reaching the MSB is never closed. This is the sign handling of
//       two's-complement B.
//   DONE: done=1, ready=1. Stays in DONE until rstN. start is ignored.
//   start is ignored in RUN and DONE. Only rstN reloads the datapath.
//   Reset mid-RUN: immediate return to IDLE. The datapath reloads concurrently.
//   Widths: pos+k <= WIDTH-1 and k+1 <= WIDTH; both fit 3 bits, so no wrap is possible.
//   Latency: 1 cycle from start to RUN, plus T add/sub cycles (T = Booth transitions,
//     at most WIDTH), plus 1 terminal cycle. ready asserts T+2 cycles after the start edge.
// STRUCTURE
//   Shared package mult_pkg:
//     - state enum IDLE/RUN/DONE
//     - OP_ADD=1'b1, OP_SUB=1'b0
//     - SHW=3 (shift-amount width)
//   Sub-module booth_xition_finder (combinational) computes found and k.
//     Inputs: B, prev, n. Implemented as a masked priority encoder over
//     B ^ {B[WIDTH-2:0],prev}.
//   Top level: FSM, pos/prev/step_cnt registers, output muxing.
// TESTING (integrated with the multiplier datapath, WIDTH=4; check ACC, step_cnt, ready)
//   A=3, B=5 (0101) -> sub A<<0, add A<<1, sub A<<2, add A<<3;
//     ACC=15 (0x0F), step_cnt=4.
//   A=3, B=-1 (1111) -> single sub at shift 0 (B_shft_amt=1);
//     ACC=0xFD, step_cnt=1.
//   A=5, B=0 -> no transition; done stays 1; ACC=0, step_cnt=0, ready 2 cycles after start.
//   A=3, B=-8 (1000) -> one sub with A_shft_amt=3, B_shft_amt=4;
//     ACC=0xE8 (-24), step_cnt=1.
//   A=-2, B=6 (0110) -> sub A<<1 (k=1), then add A<<3;
//     ACC=0xF4 (-12), step_cnt=2.
//   rstN pulsed mid-RUN, then start held high through RUN -> returns to IDLE, ACC=0;
//     a re-run gives the correct product; start pulses in RUN/DONE have no effect.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier controller and its datapath.
package mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;
  localparam int   SHW    = 3;
endpackage

// File: rtl/booth_skip_controller_if.sv
// Controller <-> datapath/host signal bundle; master is the controller side.
interface booth_skip_controller_if #(parameter int WIDTH = 4);
  logic                     start;
  logic [WIDTH-1:0]         B;
  logic                     op;
  logic [mult_pkg::SHW-1:0] A_shft_amt;
  logic [mult_pkg::SHW-1:0] B_shft_amt;
  logic                     done;
  logic                     busy;
  logic                     ready;
  logic [mult_pkg::SHW-1:0] step_cnt;

  modport master (input start, B,
                  output op, A_shft_amt, B_shft_amt, done, busy, ready, step_cnt);
  modport slave  (output start, B,
                  input op, A_shft_amt, B_shft_amt, done, busy, ready, step_cnt);
endinterface

// File: rtl/booth_xition_finder.sv
// Finds the lowest in-scope Booth transition of B (bit differs from the bit below it,
// with prev standing in below bit 0), and reports its index and the bit value there.
module booth_xition_finder
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] B,
  input  logic             prev,
  input  logic [SHW-1:0]   n,
  output logic             found,
  output logic [SHW-1:0]   k,
  output logic             b_k
);
  logic [WIDTH-1:0] xit;

  assign xit = B ^ {B[WIDTH-2:0], prev};

  // Walk from MSB down so the last hit wins: lowest index has priority.
  always_comb begin
    found = 1'b0;
    k     = '0;
    b_k   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (xit[i] && (SHW'(i) < n)) begin
        found = 1'b1;
        k     = SHW'(i);
        b_k   = B[i];
      end
    end
  end
endmodule

// File: rtl/booth_skip_controller.sv
// Radix-2 Booth controller with run skipping: one add/sub per transition of signed B.
module booth_skip_controller
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rstN,
  booth_skip_controller_if.master bus
);
  state_t         state, state_nxt;
  logic [SHW-1:0] pos, pos_nxt;
  logic           prev, prev_nxt;
  logic [SHW-1:0] step, step_nxt;
  logic [SHW-1:0] n, k;
  logic           found, b_k;

  // Bits still unconsumed in the shifted datapath B register.
  assign n = SHW'(WIDTH) - pos;

  booth_xition_finder #(.WIDTH(WIDTH)) u_finder (
    .B     (bus.B),
    .prev  (prev),
    .n     (n),
    .found (found),
    .k     (k),
    .b_k   (b_k)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      pos   <= '0;
      prev  <= 1'b0;
      step  <= '0;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
      prev  <= prev_nxt;
      step  <= step_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    prev_nxt  = prev;
    step_nxt  = step;
    case (state)
      IDLE: if (bus.start) begin
        state_nxt = RUN;
        pos_nxt   = '0;
        prev_nxt  = 1'b0;
        step_nxt  = '0;
      end
      RUN: if (found) begin
        pos_nxt  = pos + k + SHW'(1);
        prev_nxt = b_k;
        step_nxt = step + SHW'(1);
      end else begin
        state_nxt = DONE;
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    bus.op         = OP_ADD;
    bus.A_shft_amt = '0;
    bus.B_shft_amt = '0;
    bus.done       = 1'b1;
    bus.busy       = 1'b0;
    bus.ready      = 1'b0;
    case (state)
      RUN: begin
        bus.busy = 1'b1;
        // 0->1 transition opens a run (subtract), 1->0 closes it (add).
        if (found) begin
          bus.done       = 1'b0;
          bus.op         = ~b_k;
          bus.A_shft_amt = pos + k;
          bus.B_shft_amt = k + SHW'(1);
        end
      end
      DONE:    bus.ready = 1'b1;
      default: ;
    endcase
  end

  assign bus.step_cnt = step;
endmodule

// File: tb/tb_booth_skip_controller.sv
// Controller plus a behavioural shift-add datapath, checked against A*B and transition counts.
module tb_booth_skip_controller;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   errors = 0;
  int   checks = 0;

  booth_skip_controller_if #(.WIDTH(W)) bus ();

  booth_skip_controller #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Datapath: loads operands on reset, updates whenever done is low.
  logic [W-1:0]   a_ld, b_ld, areg, breg;
  logic [2*W-1:0] acc, a_ext;

  assign a_ext = {{W{areg[W-1]}}, areg};
  assign bus.B = breg;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      areg <= a_ld;
      breg <= b_ld;
      acc  <= '0;
    end else if (!bus.done) begin
      acc  <= bus.op ? acc + (a_ext << bus.A_shft_amt) : acc - (a_ext << bus.A_shft_amt);
      breg <= breg >> bus.B_shft_amt;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_steps(input logic [W-1:0] b);
    int t = 0;
    logic lower = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (b[i] != lower) t++;
      lower = b[i];
    end
    return t;
  endfunction

  function automatic int ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p & ((1 << (2 * W)) - 1);
  endfunction

  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold_start);
    int  cyc = 0;
    bit  seen = 1'b0;
    int  t = ref_steps(b);
    int  p = ref_prod(a, b);
    a_ld = a;
    b_ld = b;
    @(negedge clk);
    rstN = 1'b0;
    #1;
    chk("rst_ready", int'(bus.ready), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 1);
    chk("rst_step", int'(bus.step_cnt), 0);
    @(negedge clk);
    rstN = 1'b1;
    bus.start = 1'b1;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      cyc++;
      #1;
      if (!hold_start) bus.start = 1'b0;
      if (cyc == 1) chk("busy_run", int'(bus.busy), 1);
      if (bus.ready) seen = 1'b1;
    end
    chk("ready_seen", int'(seen), 1);
    chk("latency", cyc, t + 2);
    chk("acc", int'(acc), p);
    chk("step_cnt", int'(bus.step_cnt), t);
    // start toggling in DONE must not restart anything
    repeat (3) begin
      @(negedge clk);
      bus.start = ~bus.start;
    end
    @(negedge clk);
    chk("done_hold_ready", int'(bus.ready), 1);
    chk("done_hold_acc", int'(acc), p);
    chk("done_hold_step", int'(bus.step_cnt), t);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    a_ld = '0;
    b_ld = '0;
    #12;
    rstN = 1'b1;

    do_mult(4'd3, 4'b0101, 1'b0);
    do_mult(4'd3, 4'b1111, 1'b0);
    do_mult(4'd5, 4'b0000, 1'b0);
    do_mult(4'd3, 4'b1000, 1'b0);
    do_mult(4'b1110, 4'b0110, 1'b0);

    // Reset mid-RUN with start held high, then re-run.
    a_ld = 4'd3;
    b_ld = 4'b0101;
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", int'(bus.busy), 1);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_acc", int'(acc), 0);
    chk("midrst_step", int'(bus.step_cnt), 0);
    do_mult(4'd3, 4'b0101, 1'b1);

    for (int r = 0; r < 30; r++)
      do_mult(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), r[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
